bwt_len_scan: RTL and testbench

//  Parametrised successor of the BWT length counter. On a start pulse it streams reads

---
 rtl/bwt_len_scan.sv | 181 ++++++++++++++++++
 tb/tb_bwt_len_scan.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_len_scan.sv
// bwt_len_scan: streams a terminator-delimited string out of the string RAM
// and reports its length, including the terminator. Reads are pipelined for
// a RAM with RD_LAT cycles of read latency. If no terminator appears within
// MAX_LEN symbols, the block flags an overflow error. A scan can be aborted.
module bwt_len_scan #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 1024,
    parameter int TERM    = 36,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr,
    output logic              ren,
    output logic              wen,
    output logic [ADDR_W:0]   len_str,
    output logic              done,
    output logic              err,
    output logic              busy
);

    // The counters are one bit wider than the address so that MAX_LEN = 2**ADDR_W fits.
    localparam logic [ADDR_W:0]   LP_MAX  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]   LP_ONE  = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] LP_TERM = DATA_W'(TERM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic              r_ren;
    logic [ADDR_W:0]   r_len;
    logic              r_done;
    logic              r_err;
    logic              r_busy;

    // r_issue_cnt counts the reads that have been issued.
    // r_chk_cnt counts the returned symbols that have been checked and did not match.
    logic [ADDR_W:0]   r_issue_cnt;
    logic [ADDR_W:0]   r_chk_cnt;

    // One bit per read in flight. Bit RD_LAT-1 marks that din holds the data for a read.
    logic [RD_LAT-1:0] r_vld_p;

    logic              w_chk_vld;
    logic              w_hit;
    logic              w_last;
    logic              w_issue_more;
    logic              w_scan_end;

    // ---- check stage: the returned symbol meets the oldest read in flight ----
    assign w_chk_vld    = r_vld_p[RD_LAT-1];
    assign w_hit        = w_chk_vld && (din == LP_TERM);
    assign w_last       = w_chk_vld && !w_hit && ((r_chk_cnt + LP_ONE) == LP_MAX);
    assign w_issue_more = (r_issue_cnt < LP_MAX);
    assign w_scan_end   = abort || w_hit || w_last;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. In SCAN, abort takes priority over a terminator match.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read issue, valid pipe, check counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_ren       <= 1'b0;
            r_len       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_issue_cnt <= '0;
            r_chk_cnt   <= '0;
            r_vld_p     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The first read goes out on the same edge that accepts start.
                    if (start) begin
                        r_addr      <= base_addr;
                        r_ren       <= 1'b1;
                        r_issue_cnt <= LP_ONE;
                        r_chk_cnt   <= '0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_vld_p     <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_scan_end) begin
                        // Reads still in flight are dropped by clearing the pipe.
                        r_ren   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_vld_p <= '0;
                        if (!abort) begin
                            r_done <= 1'b1;
                            if (w_hit) begin
                                r_len <= r_chk_cnt + LP_ONE;
                                r_err <= 1'b0;
                            end else begin
                                r_len <= LP_MAX;
                                r_err <= 1'b1;
                            end
                        end
                    end else begin
                        // ---- issue stage: the read presented this cycle enters the pipe ----
                        r_vld_p[0] <= r_ren;
                        for (int i = 1; i < RD_LAT; i++) begin
                            r_vld_p[i] <= r_vld_p[i-1];
                        end
                        if (w_issue_more) begin
                            r_ren       <= 1'b1;
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_issue_cnt <= r_issue_cnt + LP_ONE;
                        end else begin
                            r_ren <= 1'b0;
                        end
                        if (w_chk_vld) begin
                            r_chk_cnt <= r_chk_cnt + LP_ONE;
                        end
                    end
                end
                default: begin
                    r_ren   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_vld_p <= '0;
                end
            endcase
        end
    end

    assign addr    = r_addr;
    assign ren     = r_ren;
    assign wen     = 1'b0;
    assign len_str = r_len;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = r_busy;

endmodule

// File: tb/tb_bwt_len_scan.sv
// Testbench for bwt_len_scan. Two instances share one RAM image and one set of
// control inputs: a long-range instance (MAX_LEN=1024, RD_LAT=1) and a
// short-range instance (MAX_LEN=16, RD_LAT=3). A string-level model predicts,
// for each instance, the length, the error flag, the done cycle and the read
// address stream.
module tb_bwt_len_scan;

    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int DEPTH = 1024;
    localparam int TERM  = 36;

    int MAXL [2] = '{1024, 16};
    int LAT  [2] = '{1, 3};

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;

    logic [DW-1:0] din_d  [2];
    logic [AW-1:0] addr_d [2];
    logic          ren_d  [2];
    logic          wen_d  [2];
    logic [AW:0]   len_d  [2];
    logic          done_d [2];
    logic          err_d  [2];
    logic          busy_d [2];

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rd0_p [0:0];
    logic [DW-1:0] rd1_p [0:2];

    int n_cmp = 0;
    int n_bad = 0;

    bwt_len_scan #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(1024), .TERM(TERM), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .din(din_d[0]), .addr(addr_d[0]), .ren(ren_d[0]), .wen(wen_d[0]),
        .len_str(len_d[0]), .done(done_d[0]), .err(err_d[0]), .busy(busy_d[0])
    );

    bwt_len_scan #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(16), .TERM(TERM), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .din(din_d[1]), .addr(addr_d[1]), .ren(ren_d[1]), .wen(wen_d[1]),
        .len_str(len_d[1]), .done(done_d[1]), .err(err_d[1]), .busy(busy_d[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models with one and three cycles of read latency.
    always @(posedge clk) begin
        rd0_p[0] <= mem[addr_d[0]];
        rd1_p[0] <= mem[addr_d[1]];
        rd1_p[1] <= rd1_p[0];
        rd1_p[2] <= rd1_p[1];
    end
    assign din_d[0] = rd0_p[0];
    assign din_d[1] = rd1_p[2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // String-level reference: first terminator within maxl symbols from base.
    function automatic void model_scan(input int base, input int maxl, output int len, output bit e);
        for (int k = 0; k < maxl; k++) begin
            if (mem[(base + k) % DEPTH] == 8'(TERM)) begin
                len = k + 1;
                e   = 1'b0;
                return;
            end
        end
        len = maxl;
        e   = 1'b1;
    endfunction

    function automatic logic [DW-1:0] rand_sym();
        logic [DW-1:0] s;
        s = 8'($urandom_range(0, 255));
        if (s == 8'(TERM)) s = 8'h41;
        return s;
    endfunction

    task automatic put_string(input int base, input int nsym, input bit with_term);
        for (int i = 0; i < nsym; i++) mem[(base + i) % DEPTH] = rand_sym();
        if (with_term) mem[(base + nsym) % DEPTH] = 8'(TERM);
    endtask

    // One scan on both instances, checking the addresses, the done timing, the result and the busy flag.
    task automatic run_scan(input int base, input bit also_abort, input bit poke_start);
        int exp_len [2];
        bit exp_err [2];
        int exp_done [2];
        int exp_reads [2];
        int nreads [2];
        int ndone [2];
        int done_cyc [2];
        int bound;
        bound = 0;
        for (int d = 0; d < 2; d++) begin
            model_scan(base, MAXL[d], exp_len[d], exp_err[d]);
            exp_done[d]  = exp_len[d] + LAT[d];
            exp_reads[d] = (exp_len[d] + LAT[d] < MAXL[d]) ? exp_len[d] + LAT[d] : MAXL[d];
            nreads[d]    = 0;
            ndone[d]     = 0;
            done_cyc[d]  = -1;
            if (exp_done[d] > bound) bound = exp_done[d];
        end
        bound = bound + 4;
        @(negedge clk);
        base_addr = AW'(base);
        start     = 1'b1;
        abort     = also_abort;
        @(posedge clk);
        #1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        for (int cyc = 0; cyc <= bound; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (cyc == 0) begin
                    n_cmp++;
                    if (busy_d[d] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL busy_start dut%0d: got %b, required 1", d, busy_d[d]);
                    end
                end
                if (ren_d[d] === 1'b1) begin
                    n_cmp++;
                    if (addr_d[d] !== AW'((base + nreads[d]) % DEPTH)) begin
                        n_bad++;
                        $display("FAIL addr dut%0d read %0d: got %0d, required %0d", d, nreads[d], addr_d[d], (base + nreads[d]) % DEPTH);
                    end
                    nreads[d]++;
                end
                if (done_d[d] === 1'b1) begin
                    ndone[d]++;
                    if (ndone[d] == 1) begin
                        done_cyc[d] = cyc;
                        n_cmp++;
                        if (len_d[d] !== 11'(exp_len[d]) || err_d[d] !== exp_err[d] || busy_d[d] !== 1'b0) begin
                            n_bad++;
                            $display("FAIL result dut%0d base %0d: got len=%0d err=%b busy=%b, required len=%0d err=%b busy=0",
                                     d, base, len_d[d], err_d[d], busy_d[d], exp_len[d], exp_err[d]);
                        end
                    end
                end
            end
            if (poke_start && cyc == 1) begin
                start     = 1'b1;
                base_addr = AW'((base + 37) % DEPTH);
            end
            if (cyc == 2) start = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (ndone[d] != 1 || done_cyc[d] != exp_done[d]) begin
                n_bad++;
                $display("FAIL done_timing dut%0d base %0d: got %0d pulses first at E0+%0d, required 1 pulse at E0+%0d",
                         d, base, ndone[d], done_cyc[d], exp_done[d]);
            end
            n_cmp++;
            if (nreads[d] != exp_reads[d]) begin
                n_bad++;
                $display("FAIL read_count dut%0d base %0d: got %0d, required %0d", d, base, nreads[d], exp_reads[d]);
            end
            n_cmp++;
            if (len_d[d] !== 11'(exp_len[d]) || err_d[d] !== exp_err[d]) begin
                n_bad++;
                $display("FAIL hold dut%0d: got len=%0d err=%b, required len=%0d err=%b", d, len_d[d], err_d[d], exp_len[d], exp_err[d]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({addr_d[d], ren_d[d], wen_d[d], len_d[d], done_d[d], err_d[d], busy_d[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got addr=%0d ren=%b wen=%b len=%0d done=%b err=%b busy=%b, required all 0",
                         d, addr_d[d], ren_d[d], wen_d[d], len_d[d], done_d[d], err_d[d], busy_d[d]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_banana();
        logic [DW-1:0] s [7];
        s = '{8'h42, 8'h41, 8'h4E, 8'h41, 8'h4E, 8'h41, 8'h24};
        for (int i = 0; i < 7; i++) mem[i] = s[i];
        run_scan(0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        mem[1020] = 8'h41; mem[1021] = 8'h42; mem[1022] = 8'(TERM);
        run_scan(1020, 1'b0, 1'b0);
        mem[1022] = 8'h41; mem[1023] = 8'h42; mem[0] = 8'(TERM);
        run_scan(1022, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_sym();
        run_scan($urandom_range(0, DEPTH - 1), 1'b0, 1'b0);
    endtask

    task automatic test_short_latency();
        mem[5] = 8'(TERM);
        mem[6] = 8'h58;
        run_scan(5, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int b;
            int k;
            b = $urandom_range(0, DEPTH - 1);
            k = $urandom_range(0, 30);
            put_string(b, k, 1'b1);
            run_scan(b, (t == 2), t[0]);
        end
    endtask

    task automatic test_abort();
        int ndone;
        put_string(200, 2, 1'b1);
        run_scan(200, 1'b0, 1'b0);
        put_string(300, 99, 1'b1);
        @(negedge clk);
        base_addr = AW'(300);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (ren_d[d] !== 1'b0 || busy_d[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_stop dut%0d: got ren=%b busy=%b, required 0 0", d, ren_d[d], busy_d[d]);
            end
        end
        ndone = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done_d[0] === 1'b1 || done_d[1] === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d done cycles, required 0", ndone);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (len_d[d] !== 11'd3 || err_d[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_hold dut%0d: got len=%0d err=%b, required len=3 err=0", d, len_d[d], err_d[d]);
            end
        end
        run_scan(300, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        put_string(500, 19, 1'b1);
        @(negedge clk);
        base_addr = AW'(500);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({addr_d[d], ren_d[d], wen_d[d], len_d[d], done_d[d], err_d[d], busy_d[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_mid dut%0d: got addr=%0d ren=%b len=%0d done=%b err=%b busy=%b, required all 0",
                         d, addr_d[d], ren_d[d], len_d[d], done_d[d], err_d[d], busy_d[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_scan(500, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h41;
        test_reset();
        test_banana();
        test_wrap();
        test_max_len();
        test_short_latency();
        test_random();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
